// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_share_arbiter_pkg                                           |
// | Purpose  : ALU control encoding shared by the ALU arbiter and its users.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package alu_share_arbiter_pkg;

    localparam int ALU_OP_W = 8;

    typedef struct packed {
        logic [2:0] ALUSelect;
        logic [2:0] Funct3;
        logic       SubArith;
        logic       W64;
    } alu_op_t;

    localparam alu_op_t ALU_OP_NOP = '0;

endpackage : alu_share_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Purpose  : Combinational round-robin pick, search begins just above Last.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         Elig,
    input  logic [$clog2(N)-1:0] Last,
    output logic [N-1:0]         Grant
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        Grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(Last) + k) % N);
            if (!w_found && Elig[w_idx]) begin
                Grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_share_arbiter                                               |
// | Purpose  : Shares one ALU among NREQ requesters, round-robin, 1-cycle slot. |
// |            ALU_SHARE_ARBITER_PERFCNT_EN adds GrantCnt/StallCnt outputs.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NREQ-1:0]                    ReqValid,
    output logic [NREQ-1:0]                    ReqReady,
    input  logic [NREQ-1:0][WIDTH-1:0]         ReqA,
    input  logic [NREQ-1:0][WIDTH-1:0]         ReqB,
    input  logic [NREQ-1:0][ALU_OP_W-1:0]      ReqOp,
    input  logic [NREQ-1:0]                    Flush,
    output logic [WIDTH-1:0]                   AluA,
    output logic [WIDTH-1:0]                   AluB,
    output logic [ALU_OP_W-1:0]                AluOp,
    input  logic [WIDTH-1:0]                   AluResult,
    output logic [NREQ-1:0]                    RspValid,
    input  logic [NREQ-1:0]                    RspReady,
`ifdef ALU_SHARE_ARBITER_PERFCNT_EN
    output logic [NREQ-1:0][31:0]              GrantCnt,
    output logic [NREQ-1:0][31:0]              StallCnt,
`endif
    output logic [NREQ-1:0][WIDTH-1:0]         RspData
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]              r_last;
    logic [IW-1:0]              w_gidx;
    logic [NREQ-1:0]            w_elig;
    logic [NREQ-1:0]            w_grant;
    logic [NREQ-1:0]            r_rsp_valid;
    logic [NREQ-1:0][WIDTH-1:0] r_rsp_data;
    alu_op_t                    w_op;

    // A slot being drained this cycle can accept the next result.
    assign w_elig = ReqValid & ~Flush & (~r_rsp_valid | RspReady) & ~{NREQ{reset}};

    rr_arbiter #(.N(NREQ)) u_rr (
        .Elig  (w_elig),
        .Last  (r_last),
        .Grant (w_grant)
    );

    assign ReqReady = w_grant;
    assign RspValid = r_rsp_valid;
    assign RspData  = r_rsp_data;
    assign AluOp    = w_op;

    // Idle drives zeros so the ALU inputs stay quiet.
    always_comb begin
        AluA   = '0;
        AluB   = '0;
        w_op   = ALU_OP_NOP;
        w_gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                AluA   = ReqA[i];
                AluB   = ReqB[i];
                w_op   = alu_op_t'(ReqOp[i]);
                w_gidx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last      <= IW'(NREQ - 1);
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (|w_grant) begin
                r_last <= w_gidx;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (Flush[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end else if (w_grant[i]) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_data[i]  <= AluResult;
                end else if (r_rsp_valid[i] && RspReady[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef ALU_SHARE_ARBITER_PERFCNT_EN
    logic [NREQ-1:0][31:0] r_grant_cnt;
    logic [NREQ-1:0][31:0] r_stall_cnt;

    assign GrantCnt = r_grant_cnt;
    assign StallCnt = r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i]) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
                end
                if (ReqValid[i] && !w_grant[i]) begin
                    r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
                end
            end
        end
    end
`endif

endmodule : alu_share_arbiter
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_share_arbiter                                            |
// | Purpose  : Directed self-checking bench for alu_share_arbiter (2 x 64b).    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_alu_share_arbiter;

    localparam int NREQ  = 2;
    localparam int WIDTH = 64;

    logic                         clk;
    logic                         reset;
    logic [NREQ-1:0]              ReqValid;
    logic [NREQ-1:0]              ReqReady;
    logic [NREQ-1:0][WIDTH-1:0]   ReqA;
    logic [NREQ-1:0][WIDTH-1:0]   ReqB;
    logic [NREQ-1:0][7:0]         ReqOp;
    logic [NREQ-1:0]              Flush;
    logic [WIDTH-1:0]             AluA;
    logic [WIDTH-1:0]             AluB;
    logic [7:0]                   AluOp;
    logic [WIDTH-1:0]             AluResult;
    logic [NREQ-1:0]              RspValid;
    logic [NREQ-1:0]              RspReady;
    logic [NREQ-1:0][WIDTH-1:0]   RspData;
`ifdef ALU_SHARE_ARBITER_PERFCNT_EN
    logic [NREQ-1:0][31:0]        GrantCnt;
    logic [NREQ-1:0][31:0]        StallCnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqA      (ReqA),
        .ReqB      (ReqB),
        .ReqOp     (ReqOp),
        .Flush     (Flush),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluOp     (AluOp),
        .AluResult (AluResult),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
`ifdef ALU_SHARE_ARBITER_PERFCNT_EN
        .GrantCnt  (GrantCnt),
        .StallCnt  (StallCnt),
`endif
        .RspData   (RspData)
    );

    // Minimal ALU: 000 add/sub, 111 and, otherwise or.
    always_comb begin
        case (AluOp[7:5])
            3'b000:  AluResult = AluOp[1] ? (AluA - AluB) : (AluA + AluB);
            3'b111:  AluResult = AluA & AluB;
            default: AluResult = AluA | AluB;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mkop(input logic [2:0] sel, input logic sub);
        return {sel, 3'b000, sub, 1'b0};
    endfunction

    initial begin
        reset    = 1'b1;
        ReqValid = 2'b11;
        ReqA     = '0;
        ReqB     = '0;
        ReqOp    = '0;
        Flush    = '0;
        RspReady = '0;
        #2;
        check("rst_ready", 64'(ReqReady), 64'h0);
        check("rst_rspvalid", 64'(RspValid), 64'h0);
        check("rst_rspdata0", RspData[0], 64'h0);
        step();
        reset    = 1'b0;
        ReqValid = 2'b00;
        step();

        // Single requester: 5 - 3
        ReqValid = 2'b01;
        ReqA[0]  = 64'd5;
        ReqB[0]  = 64'd3;
        ReqOp[0] = mkop(3'b000, 1'b1);
        RspReady = 2'b11;
        #1;
        check("single_ready", 64'(ReqReady), 64'h1);
        check("single_alua", AluA, 64'd5);
        check("single_aluop", 64'(AluOp), 64'h02);
        step();
        check("single_rspvalid", 64'(RspValid), 64'h1);
        check("single_rspdata", RspData[0], 64'd2);

        // Idle: ALU inputs zero, undrained slot holds
        ReqValid = 2'b00;
        RspReady = 2'b00;
        #1;
        check("idle_ready", 64'(ReqReady), 64'h0);
        check("idle_alua", AluA, 64'h0);
        check("idle_alub", AluB, 64'h0);
        check("idle_aluop", 64'(AluOp), 64'h0);
        step();
        check("idle_rspvalid", 64'(RspValid), 64'h1);

        // Round-robin: pointer at 0 so requester 1 goes first
        ReqA[0]  = 64'd10;  ReqB[0] = 64'd4;  ReqOp[0] = mkop(3'b000, 1'b0);
        ReqA[1]  = 64'd100; ReqB[1] = 64'd1;  ReqOp[1] = mkop(3'b000, 1'b1);
        ReqValid = 2'b11;
        RspReady = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", 64'(ReqReady), (k % 2 == 0) ? 64'h2 : 64'h1);
            step();
            check("rr_rspvalid", 64'(RspValid), (k % 2 == 0) ? 64'h2 : 64'h1);
            if (k % 2 == 0) check("rr_data1", RspData[1], 64'd99);
            else            check("rr_data0", RspData[0], 64'd14);
        end

        // Backpressure: slot 0 full and not drained, requester 1 proceeds
        ReqA[1]  = 64'd7; ReqB[1] = 64'd2; ReqOp[1] = mkop(3'b111, 1'b0);
        RspReady = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_grant", 64'(ReqReady), 64'h2);
            step();
            check("bp_rspvalid", 64'(RspValid), 64'h3);
            check("bp_hold0", RspData[0], 64'd14);
            check("bp_data1", RspData[1], 64'd2);
        end
`ifdef ALU_SHARE_ARBITER_PERFCNT_EN
        check("perf_stall0", 64'(StallCnt[0]), 64'd5);
        check("perf_stall1", 64'(StallCnt[1]), 64'd2);
        check("perf_grant0", 64'(GrantCnt[0]), 64'd3);
        check("perf_grant1", 64'(GrantCnt[1]), 64'd5);
`endif
        ReqA[0]  = 64'd20; ReqB[0] = 64'd4;
        RspReady = 2'b11;
        #1;
        check("bp_release_grant", 64'(ReqReady), 64'h1);
        check("bp_release_alua", AluA, 64'd20);
        step();
        check("bp_release_valid", 64'(RspValid), 64'h1);
        check("bp_release_data", RspData[0], 64'd24);

        // Flush: fill slot 1, move pointer to 0, then flush requester 1
        ReqValid = 2'b10;
        RspReady = 2'b00;
        step();
        check("fl_fill_valid", 64'(RspValid), 64'h3);
        ReqValid = 2'b01;
        RspReady = 2'b01;
        ReqA[0]  = 64'd1; ReqB[0] = 64'd1;
        step();
        check("fl_ptr_valid", 64'(RspValid), 64'h3);
        Flush    = 2'b10;
        ReqValid = 2'b11;
        RspReady = 2'b11;
        ReqA[0]  = 64'd3; ReqB[0] = 64'd3;
        #1;
        check("fl_grant", 64'(ReqReady), 64'h1);
        step();
        check("fl_rspvalid", 64'(RspValid), 64'h1);
        check("fl_data0", RspData[0], 64'd6);
        Flush = 2'b00;

        // Reset while a grant to requester 1 is in flight
        RspReady = 2'b00;
        #1;
        check("rm_pre_grant", 64'(ReqReady), 64'h2);
        #3;
        reset = 1'b1;
        #1;
        check("rm_rspvalid", 64'(RspValid), 64'h0);
        check("rm_ready", 64'(ReqReady), 64'h0);
        check("rm_data0", RspData[0], 64'h0);
        step();
        reset = 1'b0;
        #1;
        check("rm_first_grant", 64'(ReqReady), 64'h1);
        step();
        check("rm_rspvalid_after", 64'(RspValid), 64'h1);
        check("rm_data_after", RspData[0], 64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_share_arbiter
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one integer ALU instance between NREQ requesters, e.g. the IEU execute path and a secondary microsequenced unit.
- Arbitrates round-robin, issuing at most one operation per cycle.
- Drives the ALU operand/control inputs combinationally from the granted request.
- Registers the ALU result into a per-requester response slot with a valid/ready handshake.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- WIDTH, 64, operand/result width; 32 or 64.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ReqValid  in  NREQ  request valid, one bit per requester.
- ReqReady  out  NREQ  grant this cycle; handshake completes when ReqValid[i]&ReqReady[i].
- ReqA  in  NREQ x WIDTH  operand A per requester.
- ReqB  in  NREQ x WIDTH  operand B per requester.
- ReqOp  in  NREQ x 8  alu_op_t per requester: ALUSelect[2:0], Funct3[2:0], SubArith, W64.
- Flush  in  NREQ  per-requester kill of the pending response and of any same-cycle grant.
- AluA  out  WIDTH  operand A to the ALU.
- AluB  out  WIDTH  operand B to the ALU.
- AluOp  out  8  alu_op_t to the ALU.
- AluResult  in  WIDTH  ALU result, combinational from AluA/AluB/AluOp.
- RspValid  out  NREQ  response valid.
- RspReady  in  NREQ  response accepted.
- RspData  out  NREQ x WIDTH  registered result per requester.

Behaviour:
- Reset (asynchronous) clears:
  - RspValid = 0, RspData = 0.
  - Round-robin pointer Last = NREQ-1, so requester 0 has first priority.
  - ReqReady is combinational and 0 while reset is asserted.
- Eligibility: Elig[i] = ReqValid[i] & ~Flush[i] & (~RspValid[i] | RspReady[i]).
  - Draining the slot in the same cycle frees it for a new grant.
- Grant:
  - One-hot over Elig.
  - Search starts at (Last+1) mod NREQ and proceeds upward with wrap.
  - ReqReady = grant vector.
  - Last updates to the granted index only on a grant; it holds otherwise.
- ALU drive:
  - With a grant: AluA/AluB/AluOp = the granted requester's fields.
  - With no grant: drive all zeros (ALUSelect=000 add of 0+0), so the ALU does not toggle.
- Latency: fixed 1 cycle. Grant in cycle N → RspValid[i]=1 and RspData[i]=AluResult sampled at the edge ending cycle N, visible in N+1.
- Response slot i, next state, in priority order:
  - Flush[i] → RspValid[i]=0.
  - Else grant[i] → RspValid[i]=1 and load RspData[i].
  - Else RspValid[i]&RspReady[i] → RspValid[i]=0.
  - Else hold.
- RspData holds its last value when not loaded.
- Flush[i] and RspReady[i] together → slot cleared; the response counts as not delivered.
- Requester with a full, undrained slot → never granted; the other requesters proceed (no head-of-line blocking).
- Throughput: back-to-back grants to the same requester are allowed when it drains every cycle, giving 1 op/cycle.
- WIDTH=32: W64 bit passed through unchanged; ALU ignores it.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_PERFCNT_EN.
- Defined:
  - Adds outputs GrantCnt and StallCnt, each NREQ x 32.
  - GrantCnt[i] increments on each grant to requester i.
  - StallCnt[i] increments each cycle ReqValid[i] & ~ReqReady[i].
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package (cvw-level):
  - alu_op_t packed struct: ALUSelect, Funct3, SubArith, W64, 8 bits.
  - ALU_OP_W = 8.
  - ALU_OP_NOP = all zeros.
- Sub-module: rr_arbiter (parameter N).
  - Inputs: Elig, Last. Output: one-hot Grant.
  - Purely combinational; reusable.
  - Pointer register stays in the parent.

Test Plan:
- Single requester:
  - Req0 A=5, B=3, ALUSelect=000, SubArith=1, RspReady=1.
  - ReqReady[0]=1 same cycle, RspValid[0]=1 next cycle, RspData[0]=2.
- Round-robin:
  - Both requesters valid continuously, both RspReady=1.
  - Grants alternate 0,1,0,1…; pointer wraps; each RspData matches its own operands.
- Backpressure:
  - Req0 slot full, RspReady[0]=0, Req0 and Req1 both valid.
  - Only Req1 granted every cycle; StallCnt[0] increments; Req0 granted the cycle RspReady[0] rises.
- Flush:
  - Flush[1] in the cycle RspValid[1]=1 and Req1 valid.
  - ReqReady[1]=0, RspValid[1]=0 next cycle, Req0 still granted.
- Idle:
  - No ReqValid.
  - AluA=AluB=0, AluOp=0, RspValid unchanged, pointer unchanged.
- Reset mid-operation:
  - Assert reset asynchronously while a grant is in flight.
  - RspValid=0 immediately; after release, first grant goes to requester 0 when both are valid.
